// File: rtl/sequence_tx.sv
// sequence_tx: serial bit-pattern transmitter.
// Latches a parallel pattern on start and shifts it out MSB-first, one bit per
// clock, optionally repeating it back-to-back (reps+1 transmissions in total).
// All outputs are registered and come from the state register.
module sequence_tx #(
   parameter int unsigned PAT_WIDTH = 4,
   parameter int unsigned REP_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic [PAT_WIDTH-1:0] pattern,
   input  logic [REP_WIDTH-1:0] reps,
   output logic                 serial_out,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned CW = (PAT_WIDTH > 2) ? $clog2(PAT_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(PAT_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [PAT_WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]        bit_q,   bit_d;
   logic [REP_WIDTH-1:0] rep_q,   rep_d;
   logic                 serial_q, serial_d;
   logic                 busy_q,   busy_d;
   logic                 done_q,   done_d;

   logic [CW-1:0]        bit_idx;

   assign bit_idx    = bit_q - CW'(1);
   assign serial_out = serial_q;
   assign busy       = busy_q;
   assign done       = done_q;

   // State and datapath registers; reset aborts any transmission in progress.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         bit_q    <= '0;
         rep_q    <= '0;
         serial_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bit_q    <= bit_d;
         rep_q    <= rep_d;
         serial_q <= serial_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state, shift sequencing and registered-output values.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bit_d    = bit_q;
      rep_d    = rep_q;
      serial_d = serial_q;
      busy_d   = busy_q;
      done_d   = done_q;

      case (state_q)
         S_IDLE: begin
            serial_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            if (start) begin
               shreg_d  = pattern;
               rep_d    = reps;
               bit_d    = LAST_BIT;
               serial_d = pattern[PAT_WIDTH-1];
               busy_d   = 1'b1;
               state_d  = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (bit_q != '0) begin
               serial_d = shreg_q[bit_idx];
               bit_d    = bit_idx;
            end else if (rep_q != '0) begin
               serial_d = shreg_q[PAT_WIDTH-1];
               bit_d    = LAST_BIT;
               rep_d    = rep_q - REP_WIDTH'(1);
            end else begin
               serial_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end
         end

         S_DONE: begin
            // The edge leaving DONE acts as the IDLE edge, so a held start
            // relaunches at k+N+1 and back-to-back transfers repeat every N+1.
            serial_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            state_d  = S_IDLE;
            if (start) begin
               shreg_d  = pattern;
               rep_d    = reps;
               bit_d    = LAST_BIT;
               serial_d = pattern[PAT_WIDTH-1];
               busy_d   = 1'b1;
               state_d  = S_SHIFT;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sequence_tx.sv
// tb_sequence_tx: directed self-checking bench for sequence_tx.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sequence_tx;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       start;
   logic [3:0] pattern;
   logic [3:0] reps;
   logic       serial_out;
   logic       busy;
   logic       done;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   sequence_tx #(
      .PAT_WIDTH(4),
      .REP_WIDTH(4)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .pattern    (pattern),
      .reps       (reps),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Count 1101 windows in a captured stream, as the downstream detector would.
   function automatic int unsigned count_1101(input logic [63:0] s, input int unsigned n);
      int unsigned c = 0;
      for (int unsigned t = 3; t < n; t++)
         if ({s[t-3], s[t-2], s[t-1], s[t]} == 4'b1101) c++;
      return c;
   endfunction

   // Launch one transmission with a one-cycle start pulse and check it end to end.
   task automatic run_tx(input string tag, input logic [3:0] pat, input logic [3:0] rep,
                         input int unsigned exp_det);
      logic [63:0] obs_s = '0;
      logic [63:0] exp_s = '0;
      int unsigned n     = 4 * (int'(rep) + 1);
      int unsigned busy_n = 0;
      int unsigned done_n = 0;
      for (int unsigned t = 0; t < n; t++) exp_s[t] = pat[3 - (t % 4)];

      start   = 1'b1;
      pattern = pat;
      reps    = rep;
      @(negedge clk);
      start   = 1'b0;
      pattern = ~pat;
      reps    = '0;
      for (int unsigned t = 0; t < n; t++) begin
         obs_s[t] = serial_out;
         if (busy) busy_n++;
         if (done) done_n++;
         @(negedge clk);
      end
      check({tag, "_stream"}, obs_s, exp_s);
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(n));
      check({tag, "_no_early_done"}, 64'(done_n), 64'd0);
      check({tag, "_detect"}, 64'(count_1101(obs_s, n)), 64'(exp_det));
      check({tag, "_end"}, {61'd0, serial_out, busy, done}, 64'b001);
      @(negedge clk);
      check({tag, "_idle"}, {61'd0, serial_out, busy, done}, 64'b000);
   endtask

   initial begin
      logic [3:0] cap;
      n_rst   = 1'b1;
      start   = 1'b0;
      pattern = '0;
      reps    = '0;

      // Power-on reset applied mid-cycle: outputs clear without a clock edge.
      #3 n_rst = 1'b0;
      #1 check("por_async", {61'd0, serial_out, busy, done}, 64'b000);
      @(negedge clk);
      check("por_hold_edge", {61'd0, serial_out, busy, done}, 64'b000);
      n_rst = 1'b1;
      @(negedge clk);
      check("por_released", {61'd0, serial_out, busy, done}, 64'b000);

      // Single and repeated 1101, plus the all-ones repeat boundary.
      run_tx("single_1101", 4'b1101, 4'd0, 1);
      run_tx("repeat_1101", 4'b1101, 4'd1, 2);
      run_tx("zeros_r2",    4'b0000, 4'd2, 0);
      run_tx("ones_r2",     4'b1111, 4'd2, 0);
      run_tx("max_reps",    4'b1101, 4'hF, 16);

      // Start held high: pattern changes after acceptance are ignored and the
      // next transfer launches exactly N+1 edges after the first acceptance.
      start   = 1'b1;
      pattern = 4'b1011;
      reps    = 4'd0;
      @(negedge clk);
      pattern = 4'b0000;
      cap[3]  = serial_out;
      for (int i = 2; i >= 0; i--) begin
         @(negedge clk);
         cap[i] = serial_out;
      end
      check("hold_stream", 64'(cap), 64'(4'b1011));
      @(negedge clk);
      check("hold_done", {61'd0, serial_out, busy, done}, 64'b001);
      pattern = 4'b1001;
      @(negedge clk);
      check("hold_restart", {61'd0, serial_out, busy, done}, 64'b110);
      start   = 1'b0;
      cap[3]  = serial_out;
      for (int i = 2; i >= 0; i--) begin
         @(negedge clk);
         cap[i] = serial_out;
      end
      check("hold_second_stream", 64'(cap), 64'(4'b1001));
      @(negedge clk);
      check("hold_second_done", {61'd0, serial_out, busy, done}, 64'b001);
      @(negedge clk);

      // Reset after the second bit of 1101: immediate abort, no done pulse.
      start   = 1'b1;
      pattern = 4'b1101;
      reps    = 4'd0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort_pre", {61'd0, serial_out, busy, done}, 64'b110);
      #2 n_rst = 1'b0;
      #1 check("abort_async", {61'd0, serial_out, busy, done}, 64'b000);
      @(negedge clk);
      @(negedge clk);
      check("abort_no_done", {61'd0, serial_out, busy, done}, 64'b000);
      n_rst = 1'b1;
      @(negedge clk);
      check("abort_idle", {61'd0, serial_out, busy, done}, 64'b000);
      run_tx("after_abort", 4'b1101, 4'd0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
